bsg_locking_arb_rr: RTL and testbench

//   Parametrised locking arbiter for inputs_p requesters, fixed-priority or round-robin.

---
 rtl/bsg_locking_arb_rr.sv | 191 +++++++++++++++++++
 tb/tb_bsg_locking_arb_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_locking_arb_rr.sv
//==============================================================================
// Module      : bsg_locking_arb_rr
// Description : Locking arbiter for inputs_p requesters. The first grant
//               issued while unlocked (and ready_i high) locks arbitration to
//               that requester until unlock_i. Arbitration is fixed-priority
//               (index 0 highest) or round-robin starting after the last
//               owner. An optional idle watchdog force-releases a lock whose
//               owner has stopped requesting.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   inputs_p   number of requesters (>=1)
//   rr_mode_p  1: round-robin from (last owner + 1); 0: fixed priority
//   timeout_p  watchdog limit in consecutive owner-idle locked cycles (>=1)
// Ports
//   clk_i        in   clock, all state updates on the rising edge
//   reset_n_i    in   asynchronous active-low reset
//   ready_i      in   downstream can accept; no grant and no lock when low
//   unlock_i     in   release the lock at the next rising edge
//   reqs_i       in   request vector [inputs_p]
//   grants_o     out  one-hot or zero grant vector, combinational
//   locked_o     out  registered lock state
//   owner_id_o   out  index of the locked owner; holds last owner when unlocked
//   timeout_o    out  one-cycle pulse after a watchdog release
// Configuration macro
//   BSG_LOCKING_ARB_RR_WATCHDOG_EN  enables the idle watchdog; when undefined
//                                   timeout_o is tied low and a lock is held
//                                   until unlock_i.
//==============================================================================
`default_nettype none

module bsg_locking_arb_rr #(
  parameter int inputs_p  = 16,
  parameter int rr_mode_p = 1,
  parameter int timeout_p = 255,
  localparam int ID_W     = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                ready_i,
  input  logic                unlock_i,
  input  logic [inputs_p-1:0] reqs_i,
  output logic [inputs_p-1:0] grants_o,
  output logic                locked_o,
  output logic [ID_W-1:0]     owner_id_o,
  output logic                timeout_o
);

  localparam logic [ID_W-1:0] PTR_RESET = ID_W'(inputs_p - 1);

  logic                locked_q, locked_d;
  logic [ID_W-1:0]     owner_q,  owner_d;
  logic [ID_W-1:0]     ptr_q,    ptr_d;

  logic [inputs_p-1:0] arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_vld;
  logic [ID_W-1:0]     cand_idx;
  logic [inputs_p-1:0] grant_w;
  logic                acquire;

  //--------------------------------------------------------------------------
  // Arbitration: walk the request vector starting at ptr+1 (round-robin) or
  // at 0 (fixed priority) and take the first requester found. The modulo
  // keeps the candidate index inside 0..inputs_p-1 for any inputs_p.
  //--------------------------------------------------------------------------
  always_comb begin
    arb_gnt  = '0;
    arb_idx  = '0;
    arb_vld  = 1'b0;
    cand_idx = '0;
    for (int off = 0; off < inputs_p; off++) begin
      if (rr_mode_p != 0) begin
        cand_idx = ID_W'((int'(ptr_q) + 1 + off) % inputs_p);
      end else begin
        cand_idx = ID_W'(off);
      end
      if (!arb_vld && reqs_i[cand_idx]) begin
        arb_vld           = 1'b1;
        arb_idx           = cand_idx;
        arb_gnt[cand_idx] = 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Grant: unlocked -> arbitration result; locked -> only the owner, and only
  // while it still requests. Reset forces the output low asynchronously.
  //--------------------------------------------------------------------------
  always_comb begin
    grant_w = '0;
    if (ready_i) begin
      if (!locked_q) begin
        grant_w = arb_gnt;
      end else if (reqs_i[owner_q]) begin
        grant_w[owner_q] = 1'b1;
      end
    end
    grants_o = reset_n_i ? grant_w : '0;
  end

  assign acquire = !locked_q && ready_i && arb_vld;

`ifdef BSG_LOCKING_ARB_RR_WATCHDOG_EN
  localparam int CNT_W = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
  // Value the counter holds on the last idle cycle before release.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_p - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    locked_d  = locked_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    if (acquire) begin
      owner_d  = arb_idx;
      ptr_d    = arb_idx;
      // An unlock in the acquisition cycle wins: the grant still issues and
      // the pointer advances, but the lock is not taken.
      locked_d = !unlock_i;
    end else if (locked_q && unlock_i) begin
      locked_d = 1'b0;
    end

    // Acquisition always happens from the unlocked state, so clearing while
    // unlocked also covers the clear-on-acquire case. An explicit unlock
    // takes precedence over a simultaneous watchdog expiry.
    if (!locked_q || unlock_i || reqs_i[owner_q]) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;

    if (acquire) begin
      owner_d  = arb_idx;
      ptr_d    = arb_idx;
      // An unlock in the acquisition cycle wins: the grant still issues and
      // the pointer advances, but the lock is not taken.
      locked_d = !unlock_i;
    end else if (locked_q && unlock_i) begin
      locked_d = 1'b0;
    end
  end

  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= PTR_RESET;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

  assign locked_o   = locked_q;
  assign owner_id_o = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_locking_arb_rr.sv
//==============================================================================
// Module      : tb_bsg_locking_arb_rr
// Description : Self-checking bench for bsg_locking_arb_rr. Two 16-input
//               instances (fixed priority and round-robin, timeout_p=4) share
//               the same stimulus. Each applied vector carries its expected
//               grants and next-cycle state; vectors are queued when driven
//               and popped for comparison after the clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bsg_locking_arb_rr;

`ifdef BSG_LOCKING_ARB_RR_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct packed {
    logic        rdy;
    logic        unl;
    logic [15:0] reqs;
    logic [15:0] g_f;
    logic [15:0] g_r;
    logic        lk_f;
    logic        lk_r;
    logic [3:0]  o_f;
    logic [3:0]  o_r;
    logic        chk_o;
    logic        to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        unlock = 1'b0;
  logic [15:0] reqs = '0;

  logic [15:0] g_f, g_r;
  logic        lk_f, lk_r, to_f, to_r;
  logic [3:0]  own_f, own_r;

  int n_checks = 0;
  int n_errors = 0;
  vec_t sb_q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  bsg_locking_arb_rr #(.inputs_p(16), .rr_mode_p(0), .timeout_p(4)) u_fix (
    .clk_i(clk), .reset_n_i(rst_n), .ready_i(ready), .unlock_i(unlock),
    .reqs_i(reqs), .grants_o(g_f), .locked_o(lk_f), .owner_id_o(own_f),
    .timeout_o(to_f)
  );

  bsg_locking_arb_rr #(.inputs_p(16), .rr_mode_p(1), .timeout_p(4)) u_rr (
    .clk_i(clk), .reset_n_i(rst_n), .ready_i(ready), .unlock_i(unlock),
    .reqs_i(reqs), .grants_o(g_r), .locked_o(lk_r), .owner_id_o(own_r),
    .timeout_o(to_r)
  );

  function automatic vec_t mk(input logic rdy, input logic unl,
                              input logic [15:0] rq, input logic [15:0] gf,
                              input logic [15:0] gr, input logic lf,
                              input logic lr, input logic [3:0] of,
                              input logic [3:0] orr, input logic co,
                              input logic to);
    vec_t v;
    v.rdy = rdy; v.unl = unl; v.reqs = rq; v.g_f = gf; v.g_r = gr;
    v.lk_f = lf; v.lk_r = lr; v.o_f = of; v.o_r = orr; v.chk_o = co;
    v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector, check combinational grants, then the state after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    ready  = v.rdy;
    unlock = v.unl;
    reqs   = v.reqs;
    sb_q.push_back(v);
    #1;
    chk("grant_fix", 32'(g_f), 32'(sb_q[0].g_f));
    chk("grant_rr",  32'(g_r), 32'(sb_q[0].g_r));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("locked_fix", 32'(lk_f), 32'(e.lk_f));
    chk("locked_rr",  32'(lk_r), 32'(e.lk_r));
    if (e.chk_o) begin
      chk("owner_fix", 32'(own_f), 32'(e.o_f));
      chk("owner_rr",  32'(own_r), 32'(e.o_r));
    end
    chk("timeout_fix", 32'(to_f), 32'(e.to));
    chk("timeout_rr",  32'(to_r), 32'(e.to));
  endtask

  task automatic do_reset();
    ready  = 1'b0;
    unlock = 1'b0;
    reqs   = '0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
  endtask

  initial begin
    //                rdy  unl  reqs      g_fix     g_rr      lkf lkr of   or   chk to
    tbl[0]  = mk(1'b1, 1'b0, 16'h0014, 16'h0004, 16'h0004, 1, 1, 4'd2, 4'd2, 1, 0);
    tbl[1]  = mk(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1, 1, 4'd2, 4'd2, 1, 0);
    tbl[2]  = mk(1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1, 1, 4'd2, 4'd2, 1, 0);
    tbl[3]  = mk(1'b1, 1'b0, 16'h0004, 16'h0004, 16'h0004, 1, 1, 4'd2, 4'd2, 1, 0);
    tbl[4]  = mk(1'b1, 1'b1, 16'h0004, 16'h0004, 16'h0004, 0, 0, 4'd2, 4'd2, 1, 0);
    tbl[5]  = mk(1'b1, 1'b0, 16'h0011, 16'h0001, 16'h0010, 1, 1, 4'd0, 4'd4, 1, 0);
    tbl[6]  = mk(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd0, 4'd4, 1, 0);
    tbl[7]  = mk(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0100, 0, 0, 4'd0, 4'd0, 0, 0);
    tbl[8]  = mk(1'b1, 1'b0, 16'h0301, 16'h0001, 16'h0200, 1, 1, 4'd0, 4'd9, 1, 0);
    tbl[9]  = mk(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd0, 4'd9, 1, 0);
    tbl[10] = mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0, 4'd9, 1, 0);
    tbl[11] = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd0, 4'd9, 1, 0);

    // Reset state, with requests present to show grants are forced low.
    ready = 1'b1;
    reqs  = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant_fix", 32'(g_f), 32'h0);
    chk("rst_grant_rr",  32'(g_r), 32'h0);
    chk("rst_locked",    32'(lk_r), 32'h0);
    chk("rst_owner",     32'(own_r), 32'h0);
    chk("rst_timeout",   32'(to_r), 32'h0);
    do_reset();

    // Table: priority, lock hold, ready gating, unlock, rr search start.
    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Round-robin rotation with wrap 15 -> 0.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [3:0]  ex;
      logic [15:0] gr;
      ex = 4'(k % 16);
      gr = 16'(1) << ex;
      apply(mk(1'b1, 1'b0, 16'hFFFF, 16'h0001, gr, 1, 1, 4'd0, ex, 1, 0));
      apply(mk(1'b1, 1'b1, 16'hFFFF, 16'h0001, gr, 0, 0, 4'd0, ex, 1, 0));
    end

    // Idle watchdog: owner 3 idles, a request pulse restarts the count.
    do_reset();
    apply(mk(1'b1, 1'b0, 16'h0008, 16'h0008, 16'h0008, 1, 1, 4'd3, 4'd3, 1, 0));
    apply(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 4'd3, 4'd3, 1, 0));
    apply(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 4'd3, 4'd3, 1, 0));
    apply(mk(1'b1, 1'b0, 16'h0008, 16'h0008, 16'h0008, 1, 1, 4'd3, 4'd3, 1, 0));
    for (int k = 0; k < 3; k++)
      apply(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 4'd3, 4'd3, 1, 0));
    apply(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, !WD, !WD, 4'd3, 4'd3, 1, WD));
    apply(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, !WD, !WD, 4'd3, 4'd3, 1, 0));
    apply(mk(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd3, 4'd3, 1, 0));

    // Asynchronous reset while locked, then first grant goes to index 0.
    do_reset();
    apply(mk(1'b1, 1'b0, 16'h0020, 16'h0020, 16'h0020, 1, 1, 4'd5, 4'd5, 1, 0));
    reqs = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant_fix", 32'(g_f), 32'h0);
    chk("async_grant_rr",  32'(g_r), 32'h0);
    chk("async_locked",    32'(lk_r), 32'h0);
    chk("async_owner",     32'(own_r), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 1, 1, 4'd0, 4'd0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
